count_sequencer: RTL and testbench
==================================

// Module: count_sequencer
// PURPOSE
//  Command-driven controller and datapath for the 8-bit user counter behind uo_out.
//  Accepts opcodes over a valid/ready bus and sequences the count: load, start, pause,
//  resume and clear. Applies a programmable prescaler, count direction and terminal limit,
//  with one-shot or auto-reload modes. Flags terminal events to the top level.
// PARAMETERS
//  WIDTH       8  count, base and limit width
//  PRESCALE_W  4  prescaler reload width; a tick occurs every (presc+1) RUN cycles
// PORTS
//  clk        in   1           clock
//  rst_n      in   1           reset; asynchronous, active-low
//  cmd_valid  in   1           command present
//  cmd_op     in   3           opcode (see BEHAVIOUR)
//  cmd_data   in   WIDTH       command operand
//  cmd_ready  out  1           command accepted when cmd_valid & cmd_ready
//  count      out  WIDTH       current count (drives uo_out)
//  state      out  2           0 IDLE, 1 RUN, 2 PAUSE, 3 DONE
//  done       out  1           1-cycle pulse on one-shot terminal
//  wrap       out  1           1-cycle pulse on auto-reload terminal
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - count=0, state=IDLE, done=0, wrap=0.
//   - base=0, limit=all-ones, presc=0, dir=up, reload=0, prescaler cnt=0.
//  Opcodes
//   - 0 SET_MODE: dir=data[0] (1=down); reload=data[1].
//   - 1 LOAD: base=data; count=data if not RUN.
//   - 2 SET_LIMIT: limit=data.
//   - 3 SET_PRESCALE: presc=data[PRESCALE_W-1:0].
//   - 4 START: count=base, pcnt=0, state->RUN. Legal in IDLE/DONE/PAUSE.
//   - 5 STOP: RUN->PAUSE; count and pcnt held.
//   - 6 RESUME: PAUSE->RUN; count and pcnt continue.
//   - 7 CLEAR: any state->IDLE; count=0, pcnt=0; config registers kept.
//   - Opcodes that are legal-but-inapplicable (e.g. RESUME in IDLE) are accepted and ignored.
//  Ready rule
//   - cmd_ready=1 in IDLE, PAUSE and DONE.
//   - In RUN, cmd_ready=1 only for op 5 and op 7; it is combinational on cmd_op and state only.
//   - All state and register updates take effect on the clock edge of acceptance.
//  Tick
//   - In RUN, pcnt increments each cycle; tick=1 when pcnt==presc, and pcnt then wraps to 0.
//   - First tick occurs presc+1 cycles after RUN is entered.
//  Step
//   - On tick, if count!=limit: count=count+1 (up) or count-1 (down), modulo 2^WIDTH.
//   - Both directions wrap through 0/all-ones until count equals limit.
//  Terminal (tick while count==limit)
//   - reload=1: count=base, wrap=1, state stays RUN.
//   - reload=0: count held, done=1, state->DONE.
//   - base==limit: terminal fires on the first tick.
//  Simultaneous events
//   - CLEAR accepted on a terminal tick: CLEAR wins; no done or wrap pulse.
//   - STOP accepted on a tick: the step/terminal applies first, then PAUSE.
//     If that tick is a one-shot terminal, DONE wins and done pulses.
//  Mid-operation
//   - Config changes take effect at the next tick or START.
//   - Reset asserted mid-RUN: all outputs return to reset values immediately (async).
// TESTING
//  1 Reset, LOAD 5, SET_LIMIT 9, START, presc=0 -> count 5,6,7,8,9 on successive cycles;
//    done pulses on the tick at 9; state=3; count holds 9.
//  2 presc=3, base 0, limit 2, reload=1 -> count steps every 4 cycles: 0,1,2,0;
//    wrap pulses once per 12 cycles; state stays 1.
//  3 Down mode, base 2, limit 254, presc=0 -> 2,1,0,255,254 then done; checks the modulo wrap.
//  4 STOP mid-run at count 4 -> state=2, count frozen 4 for 10 cycles;
//    RESUME -> 5 follows after the remaining prescale.
//  5 In RUN, drive op 2 -> cmd_ready=0 and limit unchanged; op 5 -> cmd_ready=1.
//    CLEAR on a terminal tick -> IDLE, count 0, no done.
//  6 rst_n low asynchronously mid-RUN (between edges) -> count=0, state=0 before the next edge;
//    after release, START reruns from base=0.

Source files
------------

// File: rtl/count_sequencer_if.sv
// Command bus and status outputs of the user counter sequencer.
// The master side issues opcodes and observes the count; the slave side is the sequencer.
interface count_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_ready;
    logic [WIDTH-1:0] count;
    logic [1:0]       state;
    logic             done;
    logic             wrap;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, count, state, done, wrap
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, count, state, done, wrap
    );
endinterface

// File: rtl/count_sequencer.sv
// Command-driven sequencer for the 8-bit user counter: prescaled up/down counting
// toward a terminal limit, with one-shot (done) or auto-reload (wrap) behaviour.
module count_sequencer #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    count_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] OP_SET_MODE     = 3'd0;
    localparam logic [2:0] OP_LOAD         = 3'd1;
    localparam logic [2:0] OP_SET_LIMIT    = 3'd2;
    localparam logic [2:0] OP_SET_PRESCALE = 3'd3;
    localparam logic [2:0] OP_START        = 3'd4;
    localparam logic [2:0] OP_STOP         = 3'd5;
    localparam logic [2:0] OP_RESUME       = 3'd6;
    localparam logic [2:0] OP_CLEAR        = 3'd7;

    localparam logic [WIDTH-1:0]      CNT_ONE = WIDTH'(1);
    localparam logic [PRESCALE_W-1:0] PS_ONE  = PRESCALE_W'(1);

    state_t                r_state;
    logic [WIDTH-1:0]      r_count;
    logic [WIDTH-1:0]      r_base;
    logic [WIDTH-1:0]      r_limit;
    logic [PRESCALE_W-1:0] r_presc;
    logic [PRESCALE_W-1:0] r_pcnt;
    logic                  r_dir;
    logic                  r_reload;
    logic                  r_done;
    logic                  r_wrap;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_tick;
    logic                  w_at_limit;
    logic                  w_oneshot_term;
    logic [WIDTH-1:0]      w_step;

    // While running only STOP and CLEAR can be taken; everything else waits.
    always_comb begin
        w_ready = (r_state != S_RUN) || (bus.cmd_op == OP_STOP) || (bus.cmd_op == OP_CLEAR);
    end

    // Tick, step value and terminal detection for the current cycle.
    always_comb begin
        w_accept       = bus.cmd_valid & w_ready;
        w_tick         = (r_state == S_RUN) && (r_pcnt == r_presc);
        w_at_limit     = (r_count == r_limit);
        w_oneshot_term = w_tick & w_at_limit & ~r_reload;
        w_step         = r_dir ? (r_count - CNT_ONE) : (r_count + CNT_ONE);
    end

    // Sequencer FSM and datapath: the tick/terminal update is applied first, then an
    // accepted command overrides it (CLEAR beats a terminal; STOP yields to one-shot DONE).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_base   <= '0;
            r_limit  <= '1;
            r_presc  <= '0;
            r_pcnt   <= '0;
            r_dir    <= 1'b0;
            r_reload <= 1'b0;
            r_done   <= 1'b0;
            r_wrap   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_wrap <= 1'b0;

            if (r_state == S_RUN) begin
                if (w_tick) begin
                    r_pcnt <= '0;
                    if (!w_at_limit) begin
                        r_count <= w_step;
                    end else if (r_reload) begin
                        r_count <= r_base;
                        r_wrap  <= 1'b1;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end else begin
                    r_pcnt <= r_pcnt + PS_ONE;
                end
            end

            if (w_accept) begin
                case (bus.cmd_op)
                    OP_SET_MODE: begin
                        r_dir    <= bus.cmd_data[0];
                        r_reload <= bus.cmd_data[1];
                    end
                    OP_LOAD: begin
                        r_base <= bus.cmd_data;
                        if (r_state != S_RUN) begin
                            r_count <= bus.cmd_data;
                        end
                    end
                    OP_SET_LIMIT: begin
                        r_limit <= bus.cmd_data;
                    end
                    OP_SET_PRESCALE: begin
                        r_presc <= bus.cmd_data[PRESCALE_W-1:0];
                    end
                    OP_START: begin
                        if (r_state != S_RUN) begin
                            r_count <= r_base;
                            r_pcnt  <= '0;
                            r_state <= S_RUN;
                        end
                    end
                    OP_STOP: begin
                        if ((r_state == S_RUN) && !w_oneshot_term) begin
                            r_state <= S_PAUSE;
                        end
                    end
                    OP_RESUME: begin
                        if (r_state == S_PAUSE) begin
                            r_state <= S_RUN;
                        end
                    end
                    OP_CLEAR: begin
                        r_state <= S_IDLE;
                        r_count <= '0;
                        r_pcnt  <= '0;
                        r_done  <= 1'b0;
                        r_wrap  <= 1'b0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.cmd_ready = w_ready;
    assign bus.count     = r_count;
    assign bus.state     = r_state;
    assign bus.done      = r_done;
    assign bus.wrap      = r_wrap;

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: directed scenarios plus randomized commands, all checked
// against a cycle-level behavioural model of the counter kept in plain integers.
module tb_count_sequencer;

    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    count_sequencer_if #(.WIDTH(W)) cif ();

    count_sequencer #(.WIDTH(W), .PRESCALE_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (cif)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model state (0 IDLE, 1 RUN, 2 PAUSE, 3 DONE)
    int m_count, m_base, m_limit, m_presc, m_pcnt, m_state;
    bit m_dir, m_reload, m_done, m_wrap;

    // copies of what the bench is currently driving
    bit d_valid;
    int d_op, d_data;

    logic [11:0] obs;
    assign obs = {cif.count, cif.state, cif.done, cif.wrap};

    function automatic logic [11:0] exp_pack();
        logic [7:0] c;
        logic [1:0] s;
        c = m_count[7:0];
        s = m_state[1:0];
        return {c, s, m_done, m_wrap};
    endfunction

    function automatic bit m_ready(input int op);
        return (m_state != 1) || (op == 5) || (op == 7);
    endfunction

    task automatic model_reset();
        m_count = 0; m_base = 0; m_limit = 255; m_presc = 0; m_pcnt = 0;
        m_state = 0; m_dir = 0; m_reload = 0; m_done = 0; m_wrap = 0;
    endtask

    // One clock of the counter's rules, applied to the command held on the bus.
    task automatic model_clock();
        bit acc;
        int pre;
        pre = m_state;
        acc = d_valid && m_ready(d_op);
        m_done = 0;
        m_wrap = 0;
        if (acc && d_op == 7) begin
            m_state = 0; m_count = 0; m_pcnt = 0;
            return;
        end
        if (pre == 1) begin
            if (m_pcnt == m_presc) begin
                m_pcnt = 0;
                if (m_count != m_limit)
                    m_count = m_dir ? (m_count + 255) % 256 : (m_count + 1) % 256;
                else if (m_reload) begin
                    m_count = m_base; m_wrap = 1;
                end else begin
                    m_done = 1; m_state = 3;
                end
            end else begin
                m_pcnt = m_pcnt + 1;
            end
        end
        if (acc) begin
            case (d_op)
                0: begin m_dir = (d_data & 1) != 0; m_reload = (d_data & 2) != 0; end
                1: begin m_base = d_data; if (pre != 1) m_count = d_data; end
                2: m_limit = d_data;
                3: m_presc = d_data % 16;
                4: begin m_count = m_base; m_pcnt = 0; m_state = 1; end
                5: if (m_state == 1) m_state = 2;
                6: if (pre == 2) m_state = 1;
                default: ;
            endcase
        end
    endtask

    task automatic drive(input bit v, input int op, input int data);
        d_valid = v; d_op = op; d_data = data;
        cif.cmd_valid = v;
        cif.cmd_op    = op[2:0];
        cif.cmd_data  = data[7:0];
        #1;
    endtask

    task automatic clk_step();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic cmd(input int op, input int data);
        drive(1, op, data);
        clk_step();
        drive(0, 0, 0);
    endtask

    task automatic test_reset();
        n_checks++; if (cif.count !== 8'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", cif.count); end
        n_checks++; if (cif.state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", cif.state); end
        n_checks++; if (cif.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", cif.done); end
        n_checks++; if (cif.wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap got %b want 0", cif.wrap); end
        n_checks++; if (cif.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", cif.cmd_ready); end
    endtask

    task automatic test_oneshot();
        int seq[5] = '{5, 6, 7, 8, 9};
        cmd(1, 5); cmd(2, 9); cmd(3, 0); cmd(0, 0); cmd(4, 0);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (cif.count !== seq[i][7:0] || cif.state !== 2'd1 || cif.done !== 1'b0) begin
                n_fail++; $display("FAIL oneshot_seq[%0d] got count=%0d state=%0d done=%b want count=%0d state=1 done=0", i, cif.count, cif.state, cif.done, seq[i]);
            end
            clk_step();
        end
        n_checks++;
        if (cif.done !== 1'b1 || cif.state !== 2'd3 || cif.count !== 8'd9) begin
            n_fail++; $display("FAIL oneshot_done got done=%b state=%0d count=%0d want 1/3/9", cif.done, cif.state, cif.count);
        end
        clk_step();
        n_checks++;
        if (cif.done !== 1'b0 || cif.state !== 2'd3 || cif.count !== 8'd9) begin
            n_fail++; $display("FAIL oneshot_hold got done=%b state=%0d count=%0d want 0/3/9", cif.done, cif.state, cif.count);
        end
    endtask

    task automatic test_prescale_reload();
        int wraps = 0;
        cmd(7, 0); cmd(0, 2); cmd(3, 3); cmd(1, 0); cmd(2, 2); cmd(4, 0);
        for (int i = 0; i < 24; i++) begin
            clk_step();
            if (cif.wrap === 1'b1) wraps++;
            n_checks++;
            if (obs !== exp_pack()) begin
                n_fail++; $display("FAIL presc_reload cyc %0d got %h want %h", i, obs, exp_pack());
            end
        end
        n_checks++;
        if (wraps != 2 || cif.state !== 2'd1) begin
            n_fail++; $display("FAIL presc_wrap_count got wraps=%0d state=%0d want 2/1", wraps, cif.state);
        end
    endtask

    task automatic test_down();
        int seq[5] = '{2, 1, 0, 255, 254};
        cmd(7, 0); cmd(0, 1); cmd(3, 0); cmd(1, 2); cmd(2, 254); cmd(4, 0);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (cif.count !== seq[i][7:0] || cif.state !== 2'd1) begin
                n_fail++; $display("FAIL down_seq[%0d] got count=%0d state=%0d want %0d/1", i, cif.count, cif.state, seq[i]);
            end
            clk_step();
        end
        n_checks++;
        if (cif.done !== 1'b1 || cif.state !== 2'd3 || cif.count !== 8'd254) begin
            n_fail++; $display("FAIL down_done got done=%b state=%0d count=%0d want 1/3/254", cif.done, cif.state, cif.count);
        end
    endtask

    task automatic test_stop_resume();
        bit seen = 0;
        cmd(7, 0); cmd(0, 0); cmd(3, 2); cmd(1, 0); cmd(2, 200); cmd(4, 0);
        for (int i = 0; i < 60 && !seen; i++) begin
            if (cif.count === 8'd4) seen = 1;
            else clk_step();
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL stop_reach4 got count=%0d want 4 within 60 cycles", cif.count); end
        cmd(5, 0);
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (cif.state !== 2'd2 || cif.count !== 8'd4) begin
                n_fail++; $display("FAIL stop_frozen cyc %0d got state=%0d count=%0d want 2/4", i, cif.state, cif.count);
            end
            clk_step();
        end
        cmd(6, 0);
        clk_step();
        n_checks++;
        if (cif.count !== 8'd4 || cif.state !== 2'd1) begin
            n_fail++; $display("FAIL resume_wait got count=%0d state=%0d want 4/1", cif.count, cif.state);
        end
        clk_step();
        n_checks++;
        if (cif.count !== 8'd5 || obs !== exp_pack()) begin
            n_fail++; $display("FAIL resume_step got %h want %h (count 5)", obs, exp_pack());
        end
    endtask

    task automatic test_ready_and_clear();
        bit fin = 0;
        cmd(7, 0); cmd(0, 0); cmd(3, 0); cmd(1, 0); cmd(2, 6); cmd(4, 0);
        drive(1, 2, 33);
        n_checks++;
        if (cif.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL run_ready_op2 got %b want 0", cif.cmd_ready); end
        clk_step();
        drive(1, 5, 0);
        n_checks++;
        if (cif.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL run_ready_op5 got %b want 1", cif.cmd_ready); end
        clk_step();
        drive(0, 0, 0);
        n_checks++;
        if (cif.state !== 2'd2 || cif.count !== 8'd2) begin
            n_fail++; $display("FAIL run_stop got state=%0d count=%0d want 2/2", cif.state, cif.count);
        end
        cmd(6, 0);
        for (int i = 0; i < 12 && !fin; i++) begin
            if (cif.done === 1'b1) fin = 1;
            else clk_step();
        end
        n_checks++;
        if (!fin || cif.count !== 8'd6 || cif.state !== 2'd3) begin
            n_fail++; $display("FAIL limit_kept got fin=%b count=%0d state=%0d want 1/6/3", fin, cif.count, cif.state);
        end
        cmd(7, 0); cmd(1, 3); cmd(2, 3); cmd(4, 0);
        drive(1, 7, 0);
        clk_step();
        drive(0, 0, 0);
        n_checks++;
        if (cif.state !== 2'd0 || cif.count !== 8'd0 || cif.done !== 1'b0 || cif.wrap !== 1'b0) begin
            n_fail++; $display("FAIL clear_on_terminal got state=%0d count=%0d done=%b wrap=%b want 0/0/0/0", cif.state, cif.count, cif.done, cif.wrap);
        end
        clk_step();
        n_checks++;
        if (obs !== exp_pack() || cif.done !== 1'b0) begin
            n_fail++; $display("FAIL clear_after got %h want %h", obs, exp_pack());
        end
    endtask

    task automatic test_async_reset();
        cmd(7, 0); cmd(1, 7); cmd(2, 100); cmd(3, 0); cmd(4, 0);
        clk_step(); clk_step(); clk_step();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (cif.count !== 8'd0 || cif.state !== 2'd0) begin
            n_fail++; $display("FAIL async_reset got count=%0d state=%0d want 0/0", cif.count, cif.state);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (obs !== 12'h000) begin n_fail++; $display("FAIL reset_held got %h want 000", obs); end
        @(negedge clk);
        rst_n = 1'b1;
        cmd(4, 0);
        n_checks++;
        if (cif.count !== 8'd0 || cif.state !== 2'd1) begin
            n_fail++; $display("FAIL restart got count=%0d state=%0d want 0/1", cif.count, cif.state);
        end
        clk_step(); clk_step();
        n_checks++;
        if (cif.count !== 8'd2 || obs !== exp_pack()) begin
            n_fail++; $display("FAIL restart_run got %h want %h (count 2)", obs, exp_pack());
        end
    endtask

    task automatic test_random();
        int op, data;
        cmd(7, 0);
        for (int i = 0; i < 800; i++) begin
            op = $urandom_range(0, 7);
            if (op == 7 && $urandom_range(0, 3) != 0) op = 4;
            case (op)
                1, 2:    data = $urandom_range(0, 15);
                3:       data = $urandom_range(0, 3);
                default: data = $urandom_range(0, 255);
            endcase
            drive($urandom_range(0, 2) == 0, op, data);
            n_checks++;
            if (cif.cmd_ready !== m_ready(op)) begin
                n_fail++; $display("FAIL rand_ready cyc %0d op %0d got %b want %b", i, op, cif.cmd_ready, m_ready(op));
            end
            clk_step();
            n_checks++;
            if (obs !== exp_pack()) begin
                n_fail++; $display("FAIL rand_state cyc %0d got %h want %h", i, obs, exp_pack());
            end
        end
        drive(0, 0, 0);
    endtask

    initial begin
        model_reset();
        drive(0, 0, 0);
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        test_reset();
        test_oneshot();
        test_prescale_reload();
        test_down();
        test_stop_resume();
        test_ready_and_clear();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
